// File: rtl/crc_job_sequencer.sv
// rtl/crc_job_sequencer.sv - round-robin sequencer sharing a memory-mapped CRC engine
module crc_job_sequencer #(
    parameter int          NREQ = 2,
    parameter int          LENW = 8,
    parameter logic [31:0] BASE = 32'h4003_2000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NREQ-1:0]        req,
    input  logic [32*NREQ-1:0]     req_ctrl,
    input  logic [32*NREQ-1:0]     req_poly,
    input  logic [32*NREQ-1:0]     req_seed,
    input  logic [LENW*NREQ-1:0]   req_len,
    input  logic [NREQ-1:0]        w_valid,
    input  logic [32*NREQ-1:0]     w_data,
    output logic [NREQ-1:0]        w_ready,
    output logic [NREQ-1:0]        gnt,
    output logic [NREQ-1:0]        done,
    output logic [31:0]            result,
    output logic                   busy,
    output logic                   Sel,
    output logic                   RW,
    output logic [31:0]            addr,
    output logic [31:0]            data_wr,
    input  logic [31:0]            data_rd
);
    localparam int          IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [31:0] WAS = 32'h0200_0000;

    typedef enum logic [2:0] {
        IDLE, W_CTRLS, W_POLY, W_SEED, W_CTRL, STREAM, READ, DONE
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, gidx, pick_idx, low_idx, high_idx;
    logic            low_any, high_any;
    logic [31:0]     ctrl_q, poly_q, seed_q;
    logic [LENW-1:0] cnt;
    logic            xfer;

    assign xfer = (state == STREAM) && w_valid[gidx];

    // Round-robin pick: lowest request at or above the pointer, else wrap to the lowest overall
    always_comb begin
        low_idx  = '0;
        high_idx = '0;
        low_any  = 1'b0;
        high_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                low_idx = IW'(i);
                low_any = 1'b1;
                if (i >= int'(ptr)) begin
                    high_idx = IW'(i);
                    high_any = 1'b1;
                end
            end
        end
        pick_idx = high_any ? high_idx : low_idx;
    end

    // State register; reset drops any job in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state plus the one bus transaction owned by each state
    always_comb begin
        state_nxt = state;
        Sel       = 1'b0;
        RW        = 1'b0;
        addr      = '0;
        data_wr   = '0;
        w_ready   = '0;
        case (state)
            IDLE: begin
                if (low_any) state_nxt = W_CTRLS;
            end
            W_CTRLS: begin
                Sel = 1'b1; RW = 1'b1; addr = BASE + 32'd8; data_wr = ctrl_q | WAS;
                state_nxt = W_POLY;
            end
            W_POLY: begin
                Sel = 1'b1; RW = 1'b1; addr = BASE + 32'd4; data_wr = poly_q;
                state_nxt = W_SEED;
            end
            W_SEED: begin
                Sel = 1'b1; RW = 1'b1; addr = BASE; data_wr = seed_q;
                state_nxt = W_CTRL;
            end
            W_CTRL: begin
                Sel = 1'b1; RW = 1'b1; addr = BASE + 32'd8; data_wr = ctrl_q & ~WAS;
                state_nxt = (cnt != '0) ? STREAM : READ;
            end
            STREAM: begin
                w_ready[gidx] = 1'b1;
                Sel     = w_valid[gidx];
                RW      = 1'b1;
                addr    = BASE;
                data_wr = w_data[gidx*32 +: 32];
                if (xfer && cnt == LENW'(1)) state_nxt = READ;
            end
            READ: begin
                addr      = BASE;
                state_nxt = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Job capture at grant, word countdown, result latch and grant release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt    <= '0;
            done   <= '0;
            result <= '0;
            busy   <= 1'b0;
            ptr    <= '0;
            gidx   <= '0;
            ctrl_q <= '0;
            poly_q <= '0;
            seed_q <= '0;
            cnt    <= '0;
        end else begin
            done <= '0;
            if (state == IDLE && low_any) begin
                gnt    <= NREQ'(1) << pick_idx;
                gidx   <= pick_idx;
                ctrl_q <= req_ctrl[pick_idx*32 +: 32];
                poly_q <= req_poly[pick_idx*32 +: 32];
                seed_q <= req_seed[pick_idx*32 +: 32];
                cnt    <= req_len[pick_idx*LENW +: LENW];
                busy   <= 1'b1;
            end
            if (xfer) cnt <= cnt - LENW'(1);
            if (state == READ) result <= data_rd;
            if (state == DONE) begin
                done <= gnt;
                gnt  <= '0;
                busy <= 1'b0;
                ptr  <= (gidx == IW'(NREQ - 1)) ? '0 : gidx + IW'(1);
            end
        end
    end

endmodule

// File: tb/tb_crc_job_sequencer.sv
// tb/tb_crc_job_sequencer.sv - randomized transaction-level check of crc_job_sequencer
module tb_crc_job_sequencer;
    localparam int          NREQ = 2;
    localparam int          LENW = 4;
    localparam logic [31:0] BASE = 32'h4003_2000;
    localparam logic [31:0] WAS  = 32'h0200_0000;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req = '0;
    logic [32*NREQ-1:0]   req_ctrl = '0, req_poly = '0, req_seed = '0, w_data = '0;
    logic [LENW*NREQ-1:0] req_len = '0;
    logic [NREQ-1:0]      w_valid = '0;
    logic [NREQ-1:0]      w_ready, gnt, done;
    logic [31:0]          result, addr, data_wr, data_rd;
    logic                 busy, Sel, RW;

    always #5 clk = ~clk;

    crc_job_sequencer #(.NREQ(NREQ), .LENW(LENW), .BASE(BASE)) dut (
        .clk(clk), .rst(rst), .req(req), .req_ctrl(req_ctrl), .req_poly(req_poly),
        .req_seed(req_seed), .req_len(req_len), .w_valid(w_valid), .w_data(w_data),
        .w_ready(w_ready), .gnt(gnt), .done(done), .result(result), .busy(busy),
        .Sel(Sel), .RW(RW), .addr(addr), .data_wr(data_wr), .data_rd(data_rd)
    );

    function automatic logic [31:0] fold(input logic [31:0] a, input logic [31:0] w);
        return {a[26:0], a[31:27]} ^ w;
    endfunction

    // Stand-in CRC engine: seed load while WAS is set, otherwise fold each data word
    logic [31:0] eng_acc = '0;
    logic        eng_was = 1'b0;
    always @(posedge clk) begin
        if (Sel && RW) begin
            if (addr == BASE + 32'd8) eng_was <= data_wr[25];
            else if (addr == BASE) eng_acc <= eng_was ? data_wr : fold(eng_acc, data_wr);
        end
    end
    assign data_rd = (addr == BASE) ? eng_acc : 32'hDEAD_BEEF;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-requester job descriptions presented on the request ports
    logic [31:0] cfg_ctrl [NREQ], cfg_poly [NREQ], cfg_seed [NREQ];
    int          cfg_len  [NREQ];
    logic [31:0] cfg_words[NREQ][16];

    // Reference model state for the job in flight
    bit              act = 0, done_pend = 0;
    int              n = 0, gc = 0, g = 0, rem = 0, read_at = 0, m_ptr = 0, done_g = 0, c_len = 0;
    logic [31:0]     c_ctrl, c_poly, c_seed, m_res_next;
    logic [31:0]     m_result = '0;
    logic [31:0]     c_words[16];
    logic [63:0]     exp_q[$];
    logic [NREQ-1:0] req_drv = '0, vdrv = '0, prev_gnt = '0;
    int              vmode = 0, obs_gc = 0, obs_dn = 0;

    task automatic regen(input int k);
        cfg_ctrl[k] = $urandom;
        cfg_poly[k] = $urandom;
        cfg_seed[k] = $urandom;
        cfg_len[k]  = ($urandom_range(0, 5) == 0) ? 15 : $urandom_range(0, 6);
        for (int i = 0; i < 16; i++) cfg_words[k][i] = $urandom;
    endtask

    task automatic drive();
        int rel = n - gc;
        for (int k = 0; k < NREQ; k++) begin
            logic [31:0] wd = $urandom;
            logic        wv = 1'($urandom_range(0, 1));
            if (act && g == k) begin
                if (rem > 0) wd = c_words[c_len - rem];
                case (vmode)
                    0:       wv = 1'b1;
                    1:       wv = ($urandom_range(0, 9) < 7);
                    default: wv = !(rel >= 5 && rel <= 7);
                endcase
            end
            w_data[k*32 +: 32]     = wd;
            w_valid[k]             = wv;
            vdrv[k]                = wv;
            req_ctrl[k*32 +: 32]   = cfg_ctrl[k];
            req_poly[k*32 +: 32]   = cfg_poly[k];
            req_seed[k*32 +: 32]   = cfg_seed[k];
            req_len[k*LENW +: LENW] = LENW'(cfg_len[k]);
        end
        req = req_drv;
    endtask

    task automatic check_outputs();
        int              rel;
        bit              cfg, strm, rd, dn, e_sel;
        logic [NREQ-1:0] one_g;
        logic [63:0]     head;
        logic [31:0]     e_addr, e_data;
        rel   = n - gc;
        one_g = act ? (NREQ'(1) << g) : '0;
        cfg   = act && rel <= 3;
        strm  = act && rel >= 4 && rem > 0;
        rd    = act && rel == read_at;
        dn    = act && rel == read_at + 1;
        e_sel = cfg || (strm && vdrv[g]);
        head  = (exp_q.size() > 0) ? exp_q[0] : 64'h0;
        if (cfg || strm) begin e_addr = head[63:32]; e_data = head[31:0]; end
        else if (rd)     begin e_addr = BASE;        e_data = '0; end
        else             begin e_addr = '0;          e_data = '0; end
        check("gnt", gnt, one_g);
        check("busy", busy, act);
        check("done", done, done_pend ? (NREQ'(1) << done_g) : '0);
        check("w_ready", w_ready, strm ? one_g : '0);
        check("sel", Sel, e_sel);
        check("rw", RW, cfg || strm);
        check("addr", addr, e_addr);
        check("data_wr", data_wr, e_data);
        check("result", result, m_result);
        if (dn) check("trace_drained", exp_q.size(), 0);
        if (e_sel && exp_q.size() > 0) void'(exp_q.pop_front());
        if (gnt != '0 && prev_gnt == '0) obs_gc = n;
        if (done != '0) obs_dn = n;
        prev_gnt = gnt;
    endtask

    task automatic model_update();
        int rel = n - gc;
        done_pend = 0;
        if (act) begin
            if (rel >= 4 && rem > 0 && vdrv[g]) begin
                rem--;
                if (rem == 0) read_at = rel + 1;
            end
            if (rel == 3 && c_len == 0) read_at = 4;
            if (rel == read_at) m_result = m_res_next;
            else if (rel == read_at + 1) begin
                act = 0; done_pend = 1; done_g = g;
                m_ptr = (g + 1) % NREQ;
                regen(g);
            end
        end else if (req_drv != '0) begin
            int k = 0;
            for (int i = NREQ - 1; i >= 0; i--)
                if (req_drv[(m_ptr + i) % NREQ]) k = (m_ptr + i) % NREQ;
            act = 1; gc = n + 1; g = k;
            c_ctrl = cfg_ctrl[k]; c_poly = cfg_poly[k]; c_seed = cfg_seed[k]; c_len = cfg_len[k];
            for (int i = 0; i < 16; i++) c_words[i] = cfg_words[k][i];
            rem = c_len; read_at = 1 << 20;
            exp_q.delete();
            exp_q.push_back({BASE + 32'd8, c_ctrl | WAS});
            exp_q.push_back({BASE + 32'd4, c_poly});
            exp_q.push_back({BASE, c_seed});
            exp_q.push_back({BASE + 32'd8, c_ctrl & ~WAS});
            m_res_next = c_seed;
            for (int i = 0; i < c_len; i++) begin
                exp_q.push_back({BASE, c_words[i]});
                m_res_next = fold(m_res_next, c_words[i]);
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk); #1;
        n++;
        drive();
        #1;
        check_outputs();
        model_update();
    endtask

    task automatic run_until_idle(input string tag);
        bit ok = 0;
        for (int i = 0; i < 300; i++) begin
            cycle();
            if (!act && !done_pend) begin ok = 1; break; end
        end
        check({tag, "_idle_reached"}, ok, 1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_gnt"}, gnt, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_result"}, result, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_sel"}, Sel, 0);
        check({tag, "_rw"}, RW, 0);
        check({tag, "_addr"}, addr, 0);
        check({tag, "_data_wr"}, data_wr, 0);
        check({tag, "_w_ready"}, w_ready, 0);
    endtask

    initial begin
        for (int k = 0; k < NREQ; k++) regen(k);
        drive();
        repeat (2) @(posedge clk);
        #1;
        check_reset("reset");
        #2 rst = 1'b0;

        // Single job on requester 0 with fixed data, requester 1 toggling junk
        cfg_ctrl[0] = 32'h0; cfg_poly[0] = 32'h1021; cfg_seed[0] = 32'hFFFF; cfg_len[0] = 2;
        cfg_words[0][0] = 32'h1234_5678; cfg_words[0][1] = 32'h9ABC_DEF0;
        vmode = 0;
        req_drv = 2'b01; cycle(); req_drv = '0;
        run_until_idle("single");
        check("single_latency", obs_dn - obs_gc, 8);
        check("single_result", result, fold(fold(32'hFFFF, 32'h1234_5678), 32'h9ABC_DEF0));

        // Zero-length job on requester 1 reads the seed straight back
        cfg_seed[1] = 32'hABCD; cfg_len[1] = 0;
        req_drv = 2'b10; cycle(); req_drv = '0;
        run_until_idle("len0");
        check("len0_latency", obs_dn - obs_gc, 6);
        check("len0_result", result, 32'hABCD);

        // Three-cycle valid gap mid-stream
        cfg_len[0] = 4; vmode = 2;
        req_drv = 2'b01; cycle(); req_drv = '0;
        run_until_idle("stall");
        check("stall_latency", obs_dn - obs_gc, 4 + 6 + 3);

        // Reset after the first streamed word, pointer currently favours requester 1
        cfg_len[0] = 5; vmode = 0;
        req_drv = 2'b01; cycle(); req_drv = '0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (act && rem == c_len - 1) break;
        end
        cycle();
        #1 rst = 1'b1;
        #1 check_reset("midjob_reset");
        act = 0; done_pend = 0; m_ptr = 0; m_result = '0; exp_q.delete();
        req_drv = '0; req = '0; w_valid = '0; vdrv = '0; prev_gnt = '0;
        @(posedge clk); #3 rst = 1'b0;

        // Continuous contention: grants alternate starting from requester 0
        vmode = 1;
        req_drv = 2'b11;
        cycle(); cycle();
        check("post_reset_grant", gnt, 2'b01);
        repeat (250) cycle();

        // Fully random request and valid traffic
        for (int i = 0; i < 3000; i++) begin
            req_drv = NREQ'($urandom);
            cycle();
        end
        req_drv = '0;
        run_until_idle("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/crc_job_sequencer.md
Name: crc_job_sequencer

Overview:
- Sequences the memory-mapped CRC engine on behalf of NREQ requesters and shares it between them, one job at a time.
- Arbitrates round-robin between requesters and programs CTRL, GPOLY and the seed.
- Streams the granted requester's data words into CRC_DATA, reads back the final CRC and returns it with a done pulse.
- Sits between client blocks and the CRC engine's Sel/RW/addr/data bus.

Parameters:
- NREQ, 2, number of requesters (2..8).
- LENW, 8, width of the job word-count field.
- BASE, 32'h4003_2000, CRC_DATA address; GPOLY = BASE+4, CTRL = BASE+8.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- req  in  NREQ  job request, one bit per requester
- req_ctrl  in  32*NREQ  CTRL value per requester (slice k = requester k)
- req_poly  in  32*NREQ  polynomial per requester
- req_seed  in  32*NREQ  seed per requester
- req_len  in  LENW*NREQ  number of data words per requester
- w_valid  in  NREQ  data word valid
- w_data  in  32*NREQ  data word
- w_ready  out  NREQ  data word accepted
- gnt  out  NREQ  one-hot grant
- done  out  NREQ  one-cycle job-complete pulse
- result  out  32  CRC result, held until the next done
- busy  out  1  job in progress
- Sel  out  1  CRC bus select
- RW  out  1  CRC bus 1=write, 0=read
- addr  out  32  CRC bus address
- data_wr  out  32  CRC bus write data
- data_rd  in  32  CRC bus read data, combinational from addr

Behaviour:
- Reset (async): state IDLE, round-robin pointer 0.
  - Outputs on reset: gnt=0, done=0, result=0, busy=0, Sel=0, RW=0, addr=0, data_wr=0, w_ready=0.
  - Reset mid-job aborts immediately, with no further bus activity.
- States: IDLE, W_CTRLS, W_POLY, W_SEED, W_CTRL, STREAM, READ, DONE. The state register changes on posedge clk.
- IDLE:
  - If any req bit is set, pick the first set bit searching upward from the pointer (wrapping).
  - Next cycle: gnt one-hot registered; selected req_ctrl/poly/seed/len captured into internal registers; busy=1; state W_CTRLS.
  - Bus idle in IDLE: Sel=0, RW=0.
- Bus outputs are combinational from the state and captured registers. One bus transaction per cycle:
  - W_CTRLS: Sel=1, RW=1, addr=BASE+8, data_wr = ctrl with bit 25 set (WAS=1).
  - W_POLY: Sel=1, RW=1, addr=BASE+4, data_wr=poly.
  - W_SEED: Sel=1, RW=1, addr=BASE, data_wr=seed.
  - W_CTRL: Sel=1, RW=1, addr=BASE+8, data_wr = ctrl with bit 25 cleared. Next state is STREAM if len≠0, else READ.
  - STREAM:
    - w_ready[g]=1 for the granted requester only; addr=BASE, RW=1, data_wr=w_data slice g, Sel=w_valid[g].
    - A word transfers when w_valid[g]&w_ready[g]; the counter decrements.
    - When the last word transfers, next state is READ.
    - If w_valid[g] is low, Sel=0 and the block stalls indefinitely.
  - READ: Sel=0, RW=0, addr=BASE. data_rd is captured into result at the clock edge; next state DONE.
  - DONE: done[g]=1 for one cycle, gnt cleared, busy cleared, pointer = g+1 mod NREQ, next state IDLE. No re-arbitration occurs in the DONE cycle itself.
- Latency: from grant, len+6 cycles to done with no stalls; the next grant is no earlier than 1 cycle after done.
- req is sampled only in IDLE:
  - Deasserting req mid-job does not abort the job.
  - Asserting req during a job waits until IDLE.
  - Requesters' w_valid outside their grant is ignored.
- len counter is LENW bits; len = 2^LENW−1 is the maximum. Counter underflow must not occur.
- result and RR pointer are unchanged by non-granted activity. The only bus writes are the listed states.

Test Plan:
- Single job: requester 0 with ctrl=0, poly=0x1021, seed=0xFFFF, len=2, words 0x12345678, 0x9ABCDEF0.
  - Bus trace: (0x4003_2008, 0x0200_0000), (0x4003_2004, 0x1021), (0x4003_2000, 0xFFFF), (0x4003_2008, 0), two data writes, then a read.
  - done[0] arrives 8 cycles after gnt; result = data_rd in the READ cycle.
- len=0 job: requester 1, seed=0xABCD → no STREAM cycles; done 6 cycles after gnt; result = CRC engine readback of seed.
- Contention: req=2'b11 held continuously → grants alternate 0,1,0,1; each done precedes the next gnt; result matches per job.
- Stall: w_valid[0] low for 3 cycles mid-stream → Sel=0 in those cycles, no extra writes, done delayed by exactly 3 cycles.
- Reset mid-STREAM: assert rst after first word → all outputs at reset values in the same cycle. A subsequent job re-runs the full config sequence, with requester 0 favoured.
- Isolation: requester 1 toggles w_valid while requester 0 is granted → w_ready[1]=0 and none of requester 1's data appears on data_wr.
